// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_HOLD   = 2'd2
    } rx_state_t;

    // Width for a counter that must hold max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module uart_sync_ff #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_start_detect.sv
// UART start-bit detector: majority-voted start confirmation, bit-centre
// ticks while a frame is held, and line-break detection.
module uart_rx_start_detect
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit IDLE_LEVEL  = 1'b1,
    parameter int BREAK_BITS  = 11
) (
    input  logic Clk,
    input  logic reset,
    input  logic data_in,
    input  logic sample_tick_in,
    input  logic enable_in,
    input  logic frame_done_in,
    output logic start_valid_out,
    output logic false_start_out,
    output logic bit_tick_out,
    output logic break_out,
    output logic busy_out
);

    localparam int HALF    = OVERSAMPLE / 2;
    localparam int BRK_MAX = BREAK_BITS * OVERSAMPLE;
    localparam int CNT_W   = cnt_width(HALF + 1);
    localparam int PH_W    = cnt_width(OVERSAMPLE - 1);
    localparam int BRK_W   = cnt_width(BRK_MAX);

    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF + 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [BRK_W-1:0] BRK_TOP   = BRK_W'(BRK_MAX);
    localparam logic [BRK_W-1:0] BRK_PRE   = BRK_W'(BRK_MAX - 1);
    localparam logic             START_L   = ~IDLE_LEVEL;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic             rx_s;
    logic             rx_start;
    logic             prev_s;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [PH_W-1:0]  phase, phase_nxt;
    logic [BRK_W-1:0] brk_cnt;
    logic [1:0]       samp, samp_nxt;
    logic             brk_hit;
    logic             start_nxt, false_nxt, bit_nxt, brk_nxt;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    uart_sync_ff #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (IDLE_LEVEL)
    ) u_sync (
        .clk   (Clk),
        .rst_n (rst_n),
        .d     (data_in),
        .q     (rx_s)
    );

    assign rx_start = (rx_s == START_L);
    assign brk_hit  = sample_tick_in && rx_start && (brk_cnt == BRK_PRE);
    assign cnt_inc  = cnt + CNT_W'(1);

    // Break counter runs in every state, even while disabled.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_cnt <= '0;
            prev_s  <= IDLE_LEVEL;
        end else if (sample_tick_in) begin
            prev_s <= rx_s;
            if (!rx_start) begin
                brk_cnt <= '0;
            end else if (brk_cnt != BRK_TOP) begin
                brk_cnt <= brk_cnt + BRK_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        phase_nxt = phase;
        samp_nxt  = samp;
        start_nxt = 1'b0;
        false_nxt = 1'b0;
        bit_nxt   = 1'b0;
        brk_nxt   = 1'b0;
        if (!enable_in) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            phase_nxt = '0;
        end else if (brk_hit) begin
            brk_nxt   = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            phase_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (sample_tick_in && (prev_s == IDLE_LEVEL) && rx_start) begin
                        state_nxt = ST_VERIFY;
                        cnt_nxt   = '0;
                    end
                end
                ST_VERIFY: begin
                    // cnt_inc is the tick count since the falling edge.
                    if (sample_tick_in) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_FIRST) samp_nxt[0] = rx_start;
                        if (cnt_inc == CNT_MID)   samp_nxt[1] = rx_start;
                        if (cnt_inc == CNT_LAST) begin
                            cnt_nxt = '0;
                            if (maj3(samp[0], samp[1], rx_start)) begin
                                start_nxt = 1'b1;
                                phase_nxt = PH_W'(1);
                                state_nxt = ST_HOLD;
                            end else begin
                                false_nxt = 1'b1;
                                state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_done_in) begin
                        state_nxt = ST_IDLE;
                        phase_nxt = '0;
                    end else if (sample_tick_in) begin
                        if (phase == PH_LAST) begin
                            bit_nxt   = 1'b1;
                            phase_nxt = '0;
                        end else begin
                            phase_nxt = phase + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            phase           <= '0;
            samp            <= '0;
            start_valid_out <= 1'b0;
            false_start_out <= 1'b0;
            bit_tick_out    <= 1'b0;
            break_out       <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            phase           <= phase_nxt;
            samp            <= samp_nxt;
            start_valid_out <= start_nxt;
            false_start_out <= false_nxt;
            bit_tick_out    <= bit_nxt;
            break_out       <= brk_nxt;
            busy_out        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_start_detect.sv
// Bench for uart_rx_start_detect: directed scenarios plus random line traffic
// compared tick by tick against a timeline-based reference model.
module tb_uart_rx_start_detect;

    localparam int OS        = 16;
    localparam int BRK_TICKS = 11 * OS;

    logic Clk = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b1;
    logic sample_tick_in = 1'b0;
    logic enable_in = 1'b0;
    logic frame_done_in = 1'b0;
    logic start_valid_out, false_start_out, bit_tick_out, break_out, busy_out;

    int    n_tests = 0;
    int    n_fail  = 0;
    string step    = "init";

    // Reference model: history of ticked line values and the active frame.
    bit hist[$];
    int run_len;
    bit act, conf;
    int st;
    bit e_sv, e_fs, e_bt, e_bk;

    uart_rx_start_detect #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2),
        .IDLE_LEVEL  (1'b1),
        .BREAK_BITS  (11)
    ) dut (
        .Clk             (Clk),
        .reset           (reset),
        .data_in         (data_in),
        .sample_tick_in  (sample_tick_in),
        .enable_in       (enable_in),
        .frame_done_in   (frame_done_in),
        .start_valid_out (start_valid_out),
        .false_start_out (false_start_out),
        .bit_tick_out    (bit_tick_out),
        .break_out       (break_out),
        .busy_out        (busy_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0b expected %0b", step, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        run_len = 0;
        act = 1'b0;
        conf = 1'b0;
        st = 0;
    endtask

    // Tick t: start edge at st, votes at st+7..st+9, bit centres at st+8+16n.
    task automatic model_tick(input bit line, input bit en, input bit fd);
        int t = hist.size();
        bit prv = (t == 0) ? 1'b1 : hist[t-1];
        bit hit = (line == 1'b0) && (run_len == BRK_TICKS - 1);
        int votes;
        e_sv = 1'b0; e_fs = 1'b0; e_bt = 1'b0; e_bk = 1'b0;
        hist.push_back(line);
        if (line == 1'b0) begin
            if (run_len < BRK_TICKS) run_len++;
        end else begin
            run_len = 0;
        end
        if (!en) begin
            act = 1'b0; conf = 1'b0;
        end else if (hit) begin
            e_bk = 1'b1; act = 1'b0; conf = 1'b0;
        end else if (conf) begin
            if (fd) begin
                act = 1'b0; conf = 1'b0;
            end else if ((t - st - OS/2) % OS == 0) begin
                e_bt = 1'b1;
            end
        end else if (act) begin
            if (t - st == OS/2 + 1) begin
                votes = int'(hist[st + OS/2 - 1] == 1'b0) + int'(hist[st + OS/2] == 1'b0)
                      + int'(line == 1'b0);
                if (votes >= 2) begin
                    e_sv = 1'b1; conf = 1'b1;
                end else begin
                    e_fs = 1'b1; act = 1'b0;
                end
            end
        end else if (prv && !line) begin
            act = 1'b1; st = t;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sv"}, start_valid_out, 1'b0);
        check({tag, "_fs"}, false_start_out, 1'b0);
        check({tag, "_bt"}, bit_tick_out, 1'b0);
        check({tag, "_bk"}, break_out, 1'b0);
        check({tag, "_busy"}, busy_out, 1'b0);
    endtask

    // One sample tick window: settle the line through the synchroniser, tick once.
    task automatic do_tick(input bit line, input bit en, input bit fd, input bit rst_mid);
        @(negedge Clk);
        data_in = line;
        enable_in = en;
        repeat (3) @(negedge Clk);
        sample_tick_in = 1'b1;
        frame_done_in = fd;
        model_tick(line, en, fd);
        @(posedge Clk);
        #1;
        check("start_valid", start_valid_out, e_sv);
        check("false_start", false_start_out, e_fs);
        check("bit_tick", bit_tick_out, e_bt);
        check("break", break_out, e_bk);
        check("busy", busy_out, act);
        if (rst_mid) begin
            #1;
            reset = 1'b0;
            #1;
            check_all_zero("rst_async");
            model_reset();
            @(negedge Clk);
            sample_tick_in = 1'b0;
            frame_done_in = 1'b0;
        end else begin
            @(negedge Clk);
            sample_tick_in = 1'b0;
            frame_done_in = 1'b0;
            @(posedge Clk);
            #1;
            check("pulse_width",
                  start_valid_out | false_start_out | bit_tick_out | break_out, 1'b0);
        end
    endtask

    task automatic release_reset();
        @(negedge Clk);
        reset = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        bit lvl, en, fd;
        int len;

        model_reset();
        repeat (3) @(negedge Clk);
        step = "reset";
        check_all_zero("in_reset");
        release_reset();
        check_all_zero("after_reset");

        step = "idle";
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);

        step = "clean_start";
        for (int i = 0; i < 16; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 44; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b1, 1'b0);

        step = "fd_in_idle";
        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b1, 1'b0);

        step = "glitch";
        for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);

        step = "majority";
        for (int i = 0; i < 16; i++) do_tick((i == 8), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b1, 1'b0);

        step = "enable_drop";
        for (int i = 0; i < 16; i++) do_tick(1'b0, !(i >= 6 && i <= 9), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);

        step = "break";
        for (int i = 0; i < BRK_TICKS + 6; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b1, 1'b0);

        step = "break_vs_fd";
        for (int i = 0; i < 2; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < BRK_TICKS; i++) do_tick(1'b0, 1'b1, (i == BRK_TICKS - 1), 1'b0);
        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);

        step = "reset_in_hold";
        for (int i = 0; i < 16; i++) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 16; i < 24; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b0, 1'b1);
        release_reset();
        check_all_zero("post_abort");
        for (int i = 0; i < 20; i++) do_tick(1'b1, 1'b1, 1'b0, 1'b0);

        step = "random";
        for (int blk = 0; blk < 60; blk++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 200))
                                              : int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) begin
                en = ($urandom_range(0, 19) != 0);
                fd = conf && ($urandom_range(0, 24) == 0);
                do_tick(lvl, en, fd, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
